apb_slave_mem: RTL and testbench

- Word-addressed APB3/APB4 completer with a register-based memory. It sits directly downstream of the AXI4-Lite-to-APB bridge, and one instance hangs off each m_apb_psel bit.
- Inserts a programmable number of wait states and supports byte strobes.
- Flags out-of-range and misaligned accesses with pslverr.
- Keeps a saturating error counter for debug.

---
 rtl/apb_slave_mem.sv | 151 +++++++++++++++
 tb/tb_apb_slave_mem.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_mem
//  Purpose  : Word-addressed APB3/APB4 completer backed by a register memory.
//             The number of wait states is set at build time and byte
//             strobes are honoured. Out-of-range or misaligned accesses
//             complete with pslverr, and a saturating 8-bit counter tallies
//             those error completions.
//  Ports    : s_axi_clk      - rising-edge clock
//             s_axi_aresetn  - asynchronous active-low reset
//             psel/penable   - APB select / access-phase qualifier
//             pwrite         - 1 = write, 0 = read
//             paddr/pwdata   - byte address / write data
//             pstrb          - byte write enables
//             pprot          - accepted, no effect
//             prdata         - read data, zero unless a good read completes
//             pready         - transfer completion
//             pslverr        - error response, only together with pready
//             err_count      - saturating count of error completions
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic        s_axi_clk,
    input  logic        s_axi_aresetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    input  logic [2:0]  pprot,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [7:0]  err_count
);

    localparam int          c_IDX_W    = $clog2(MEM_DEPTH);
    // One bit wider than the bus so that ADDR_BASE + 4*MEM_DEPTH cannot wrap.
    localparam logic [32:0] c_END_ADDR = {1'b0, ADDR_BASE} + 33'(4 * MEM_DEPTH);
    localparam logic [3:0]  c_WAIT     = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t               state_q;
    logic [3:0]           wait_cnt_q;
    logic [c_IDX_W-1:0]   idx_q;
    logic                 write_q;
    logic                 err_q;
    logic [31:0]          wdata_q;
    logic [3:0]           strb_q;
    logic [7:0]           err_count_q;
    logic [7:0]           err_count_d;
    logic [31:0]          mem_q [MEM_DEPTH];

    logic                 w_setup;
    logic                 w_complete;
    logic                 w_commit;
    logic                 w_addr_err;
    logic [31:0]          w_offset;
    logic                 w_unused;

    // Setup phase is recognised in either state; in ACCESS it restarts the
    // transfer and the previously captured one is simply discarded.
    assign w_setup    = psel && !penable;
    assign w_offset   = paddr - ADDR_BASE;
    assign w_addr_err = (paddr < ADDR_BASE)
                     || ({1'b0, paddr} >= c_END_ADDR)
                     || (paddr[1:0] != 2'b00);

    assign w_complete = (state_q == ST_ACCESS) && psel && penable
                     && (wait_cnt_q == 4'd0);
    // Memory is touched only on the completing edge, so an abort or reset
    // before that edge can never leave a partially written word.
    assign w_commit   = w_complete && write_q && !err_q;

    assign err_count_d = (err_count_q == 8'hFF) ? err_count_q
                                                : err_count_q + 8'd1;

    assign pready    = w_complete;
    assign pslverr   = w_complete && err_q;
    assign prdata    = (w_complete && !err_q && !write_q) ? mem_q[idx_q] : 32'h0;
    assign err_count = err_count_q;

    // Protection bits and the offset bits outside the word index carry no
    // information once the range check has been made.
    assign w_unused = ^{pprot, w_offset[31:c_IDX_W+2], w_offset[1:0]};

    // ------------------------------------------------------------------
    // Transfer FSM with the captured setup-phase copy of the request
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= 32'h0;
            strb_q      <= 4'h0;
            err_count_q <= 8'h00;
        end else if (w_setup) begin
            state_q    <= ST_ACCESS;
            wait_cnt_q <= c_WAIT;
            idx_q      <= w_offset[c_IDX_W+1:2];
            write_q    <= pwrite;
            err_q      <= w_addr_err;
            wdata_q    <= pwdata;
            strb_q     <= pstrb;
        end else if (state_q == ST_ACCESS) begin
            if (!psel) begin
                // Requester abandoned the transfer: no write, no error count.
                state_q <= ST_IDLE;
            end else if (wait_cnt_q != 4'd0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end else begin
                state_q <= ST_IDLE;
                if (err_q) begin
                    err_count_q <= err_count_d;
                end
            end
        end
        // psel && penable while IDLE is a protocol violation and is ignored.
    end

    // ------------------------------------------------------------------
    // Storage array with per-byte write enables
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_slave_mem
//  Purpose  : Self-checking bench for apb_slave_mem. Two instances share
//             clock and reset: index 0 has no wait states, index 1 has three.
//             Each transfer pushes its expected response to a scoreboard
//             queue; the entry is popped and compared when pready rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_mem;

    localparam logic [31:0] c_BASE  = 32'h0000_1000;
    localparam int          c_DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic        psel      [2];
    logic        penable   [2];
    logic        pwrite    [2];
    logic [31:0] paddr     [2];
    logic [31:0] pwdata    [2];
    logic [3:0]  pstrb     [2];
    logic [2:0]  pprot     [2];
    logic [31:0] prdata    [2];
    logic        pready    [2];
    logic        pslverr   [2];
    logic [7:0]  err_count [2];

    apb_slave_mem #(
        .ADDR_BASE  (c_BASE),
        .MEM_DEPTH  (c_DEPTH),
        .WAIT_STATES(0)
    ) u_dut0 (
        .s_axi_clk    (clk),
        .s_axi_aresetn(rst_n),
        .psel         (psel[0]),
        .penable      (penable[0]),
        .pwrite       (pwrite[0]),
        .paddr        (paddr[0]),
        .pwdata       (pwdata[0]),
        .pstrb        (pstrb[0]),
        .pprot        (pprot[0]),
        .prdata       (prdata[0]),
        .pready       (pready[0]),
        .pslverr      (pslverr[0]),
        .err_count    (err_count[0])
    );

    apb_slave_mem #(
        .ADDR_BASE  (c_BASE),
        .MEM_DEPTH  (c_DEPTH),
        .WAIT_STATES(3)
    ) u_dut3 (
        .s_axi_clk    (clk),
        .s_axi_aresetn(rst_n),
        .psel         (psel[1]),
        .penable      (penable[1]),
        .pwrite       (pwrite[1]),
        .paddr        (paddr[1]),
        .pwdata       (pwdata[1]),
        .pstrb        (pstrb[1]),
        .pprot        (pprot[1]),
        .prdata       (prdata[1]),
        .pready       (pready[1]),
        .pslverr      (pslverr[1]),
        .err_count    (err_count[1])
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   exp_errcnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transfer starting at posedge+1; returns at the posedge+1
    // after the completion edge, so consecutive calls are back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input bit exp_err, input string tag);
        exp_t e;
        int   n;
        bit   done;
        e.is_rd = !wr;
        e.rdata = exp_err ? 32'h0 : exp_rd;
        e.err   = exp_err;
        e.lat   = (d == 0) ? 2 : 5;
        sb_q.push_back(e);
        if (exp_err && exp_errcnt[d] < 255) exp_errcnt[d]++;

        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        pstrb[d]   = strb;
        pprot[d]   = 3'b010;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        // Access-phase bus changes must not affect the captured request.
        pwrite[d]  = ~wr;
        paddr[d]   = addr ^ 32'h0000_0004;
        pwdata[d]  = ~wdata;
        pstrb[d]   = ~strb;

        n    = 2;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            if (pready[d]) begin
                done = 1'b1;
            end else begin
                check({tag, "_wait_prdata"}, prdata[d], 32'h0);
                check({tag, "_wait_pslverr"}, 32'(pslverr[d]), 32'h0);
                n++;
                @(posedge clk); #1;
            end
        end
        e = sb_q.pop_front();
        check({tag, "_latency"}, 32'(n), 32'(e.lat));
        if (done) begin
            check({tag, "_pslverr"}, 32'(pslverr[d]), 32'(e.err));
            if (e.is_rd || e.err) check({tag, "_prdata"}, prdata[d], e.rdata);
        end
        @(posedge clk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        check({tag, "_errcnt"}, 32'(err_count[d]), 32'(exp_errcnt[d]));
    endtask

    initial begin
        int  n;
        bit  seen;
        logic [31:0] a;

        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 32'h0; pwdata[d] = 32'h0; pstrb[d] = 4'h0; pprot[d] = 3'h0;
            exp_errcnt[d] = 0;
        end
        rst_n = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            check("reset_pready",  32'(pready[d]),    32'h0);
            check("reset_pslverr", 32'(pslverr[d]),   32'h0);
            check("reset_prdata",  prdata[d],         32'h0);
            check("reset_errcnt",  32'(err_count[d]), 32'h0);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- zero wait states ----------------
        xfer(0, 1'b1, c_BASE + 32'd8,  32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, "wr_deadbeef");
        xfer(0, 1'b0, c_BASE + 32'd8,  32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, "rd_deadbeef");
        xfer(0, 1'b1, c_BASE + 32'd12, 32'h1122_3344, 4'hF, 32'h0,         1'b0, "wr_word3");
        xfer(0, 1'b1, c_BASE + 32'd12, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0, "wr_strb0101");
        xfer(0, 1'b0, c_BASE + 32'd12, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0, "rd_strb");
        xfer(0, 1'b1, c_BASE + 32'd12, 32'h5555_5555, 4'h0, 32'h0,         1'b0, "wr_strb0000");
        xfer(0, 1'b0, c_BASE + 32'd12, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0, "rd_after_nostrb");

        // psel && penable without a setup phase must be ignored
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = c_BASE + 32'd12; pwdata[0] = 32'hFFFF_FFFF; pstrb[0] = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("illegal_pready", 32'(pready[0]), 32'h0);
            @(posedge clk); #1;
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        xfer(0, 1'b0, c_BASE + 32'd12, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, "rd_after_illegal");

        // last word of the window
        xfer(0, 1'b1, c_BASE + 32'd1020, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0, "wr_lastword");
        xfer(0, 1'b0, c_BASE + 32'd1020, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0, "rd_lastword");

        // errors: just past the end, then misaligned write into word 0
        xfer(0, 1'b0, c_BASE + 32'd1024, 32'h0,         4'h0, 32'h0, 1'b1, "rd_oor");
        xfer(0, 1'b1, c_BASE + 32'd2,    32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_misalign");
        xfer(0, 1'b0, c_BASE,            32'h0,         4'h0, 32'h0, 1'b0, "rd_word0");
        check("errcnt_two", 32'(err_count[0]), 32'd2);

        // ---------------- three wait states ----------------
        xfer(1, 1'b1, c_BASE + 32'd4, 32'hA5A5_5A5A, 4'hF, 32'h0,         1'b0, "ws_wr_word1");
        xfer(1, 1'b0, c_BASE + 32'd4, 32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0, "ws_rd_word1");

        for (int i = 0; i < 300; i++) begin
            case (i % 3)
                0:       a = c_BASE + 32'd1024 + 32'(4 * (i % 7));
                1:       a = c_BASE + 32'd4 + 32'(((i / 3) % 3) + 1);
                default: a = c_BASE - 32'd4;
            endcase
            xfer(1, (i % 2) == 1, a, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "sat_err");
        end
        check("errcnt_saturated", 32'(err_count[1]), 32'd255);
        xfer(1, 1'b0, c_BASE + 32'd4, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, "rd_after_errs");

        // abort: psel drops during the access phase of a write
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = c_BASE + 32'd28; pwdata[1] = 32'h1234_5678; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        check("abort_pready", 32'(pready[1]), 32'h0);
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        xfer(1, 1'b0, c_BASE + 32'd28, 32'h0, 4'h0, 32'h0, 1'b0, "rd_after_abort");
        check("abort_errcnt", 32'(err_count[1]), 32'd255);

        // reset asserted in the completing cycle of a wait-state write
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = c_BASE + 32'd20; pwdata[1] = 32'hCAFE_F00D; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (pready[1]) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rst_access_cycles", 32'(n), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        check("rst_pready",  32'(pready[1]),    32'h0);
        check("rst_pslverr", 32'(pslverr[1]),   32'h0);
        check("rst_prdata",  prdata[1],         32'h0);
        check("rst_errcnt",  32'(err_count[1]), 32'h0);
        check("rst_errcnt0", 32'(err_count[0]), 32'h0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        exp_errcnt[0] = 0;
        exp_errcnt[1] = 0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, c_BASE + 32'd20, 32'h0, 4'h0, 32'h0, 1'b0, "rd_dropped_write");
        xfer(1, 1'b0, c_BASE + 32'd4,  32'h0, 4'h0, 32'h0, 1'b0, "rd_word1_cleared");
        xfer(0, 1'b0, c_BASE + 32'd8,  32'h0, 4'h0, 32'h0, 1'b0, "rd_dut0_cleared");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
